// File: rtl/burst_pkg.sv
// burst_pkg: shared states, constants and 4 KB boundary check for the burst issuer
package burst_pkg;
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} burst_state_t;
    localparam int BEAT_BYTES     = 4;
    localparam int BOUNDARY_BYTES = 4096;
    localparam int CHK_W          = 14;
    function automatic logic crosses_4k(input logic [11:0] off, input logic [CHK_W-1:0] len_m1);
        logic [CHK_W-1:0] end_off;
        end_off = CHK_W'(off) + ((len_m1 + CHK_W'(1)) << 2);
        return end_off > CHK_W'(BOUNDARY_BYTES);
    endfunction
endpackage

// File: rtl/axi_burst_issuer.sv
// axi_burst_issuer: splits a burst command into single-beat memory write/read requests
module axi_burst_issuer
    import burst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              write_valid,
    input  logic              write_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              read_valid,
    input  logic              read_ready,
    output logic [ADDR_W-1:0] read_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       beats_issued
);
    burst_state_t      state, state_nx;
    logic [ADDR_W-1:0] cur_addr, base;
    logic [LEN_W-1:0]  remaining;
    logic              cmd_hs, reject, beat, last;

    assign base       = cmd_addr & ~ADDR_W'(3);
    assign write_addr = cur_addr;
    assign read_addr  = cur_addr;
    assign write_data = wd_data;

    // State register; reset drops any in-flight burst at once
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Handshakes, request valids and next state; write_valid follows wd_valid, never write_ready
    always_comb begin
        cmd_ready   = state == IDLE;
        busy        = state != IDLE;
        write_valid = state == WR_BURST && wd_valid;
        wd_ready    = state == WR_BURST && write_ready;
        read_valid  = state == RD_BURST;
        cmd_hs      = cmd_valid && cmd_ready;
        reject      = crosses_4k(base[11:0], CHK_W'(cmd_len));
        beat        = (write_valid && write_ready) || (read_valid && read_ready);
        last        = beat && remaining == '0;
        state_nx    = cmd_hs && !reject ? (cmd_write ? WR_BURST : RD_BURST) :
                      last              ? IDLE : state;
    end

    // Burst address/count tracking, status pulses and the running beat counter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur_addr     <= '0;
            remaining    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            beats_issued <= '0;
        end else begin
            done <= last;
            err  <= cmd_hs && reject;
            if (cmd_hs) begin
                cur_addr  <= base;
                remaining <= cmd_len;
            end else if (beat) begin
                cur_addr  <= cur_addr + ADDR_W'(BEAT_BYTES);
                remaining <= remaining - LEN_W'(1);
            end
            if (beat) beats_issued <= beats_issued + 32'd1;
        end
endmodule

// File: tb/tb_axi_burst_issuer.sv
// tb_axi_burst_issuer: directed and random bursts checked against a per-beat address/data model
module tb_axi_burst_issuer;
    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wd_valid = 0, wd_ready;
    logic [31:0] wd_data = 0;
    logic        write_valid, write_ready = 0;
    logic [31:0] write_addr, write_data;
    logic        read_valid, read_ready = 0;
    logic [31:0] read_addr;
    logic        busy, done, err;
    logic [31:0] beats_issued;
    int          errors = 0, checks = 0;
    int          exp_beats = 0;

    axi_burst_issuer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .write_valid(write_valid), .write_ready(write_ready), .write_addr(write_addr),
        .write_data(write_data), .read_valid(read_valid), .read_ready(read_ready),
        .read_addr(read_addr), .busy(busy), .done(done), .err(err), .beats_issued(beats_issued)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " cmd_ready"}, 32'(cmd_ready), 1);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " write_valid"}, 32'(write_valid), 0);
        check({tag, " read_valid"}, 32'(read_valid), 0);
        check({tag, " beats_issued"}, beats_issued, exp_beats);
    endtask

    // Issue one command and follow it beat by beat; vmask/rmask give wd_valid and ready per cycle
    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l,
                         input logic [31:0] vmask, input logic [31:0] rmask);
        int exp_addr, n, c;
        bit rej;
        exp_addr = int'(a) & ~3;
        rej = (exp_addr % 4096) + (int'(l) + 1) * 4 > 4096;
        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        wd_valid = 0; write_ready = 0; read_ready = 0;
        #1 check("cmd_ready before accept", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 0;
        if (rej) begin
            #1;
            check("reject err", 32'(err), 1);
            check("reject done", 32'(done), 0);
            check_idle_outputs("reject");
            @(negedge clk);
            #1 check("reject err one cycle", 32'(err), 0);
            check("reject no valid", 32'(write_valid | read_valid), 0);
            return;
        end
        n = 0; c = 0;
        while (n <= int'(l) && c < 2000) begin
            wd_valid    = c < 32 ? vmask[c] : 1'b1;
            wd_data     = $urandom;
            write_ready = c < 32 ? rmask[c] : 1'b1;
            read_ready  = write_ready;
            #1;
            check("busy in burst", 32'(busy), 1);
            check("cmd_ready in burst", 32'(cmd_ready), 0);
            check("done in burst", 32'(done), 0);
            if (w) begin
                check("write_valid", 32'(write_valid), 32'(wd_valid));
                check("wr read_valid", 32'(read_valid), 0);
                check("wd_ready", 32'(wd_ready), 32'(write_ready));
                if (wd_valid) begin
                    check("write_addr", write_addr, 32'(exp_addr));
                    check("write_data", write_data, wd_data);
                end
                if (wd_valid && write_ready) begin n++; exp_beats++; exp_addr += 4; end
            end else begin
                check("read_valid", 32'(read_valid), 1);
                check("rd write_valid", 32'(write_valid), 0);
                check("rd wd_ready", 32'(wd_ready), 0);
                check("read_addr", read_addr, 32'(exp_addr));
                if (read_ready) begin n++; exp_beats++; exp_addr += 4; end
            end
            c++;
            if (n <= int'(l)) @(negedge clk);
        end
        check("burst completes within budget", 32'(c < 2000), 1);
        @(negedge clk);
        wd_valid = 0; write_ready = 0; read_ready = 0;
        #1;
        check("done pulse", 32'(done), 1);
        check("err quiet", 32'(err), 0);
        check_idle_outputs("after burst");
        @(negedge clk);
        #1 check("done one cycle", 32'(done), 0);
    endtask

    initial begin
        #2;
        check("reset cmd_ready", 32'(cmd_ready), 1);
        check("reset wd_ready", 32'(wd_ready), 0);
        check("reset write_valid", 32'(write_valid), 0);
        check("reset read_valid", 32'(read_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done/err", 32'({done, err}), 0);
        check("reset beats", beats_issued, 0);
        check("reset addrs", write_addr | read_addr, 0);
        @(negedge clk);
        rst_n = 1;

        issue(1, 32'h100, 3, '1, '1);
        issue(0, 32'h203, 1, '1, 32'hFFFF_FFFC);
        issue(1, 32'h400, 2, 32'hFFFF_FFF9, '1);
        issue(1, 32'hFF8, 1, '1, '1);
        issue(0, 32'hFFC, 1, '1, '1);
        issue(1, 32'h2000, 255, $urandom, $urandom);
        issue(0, 32'h3000, 0, '1, '1);

        // reset in the middle of a 5-beat write, after 2 beats complete
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h300; cmd_len = 4;
        @(negedge clk);
        cmd_valid = 0; wd_valid = 1; write_ready = 1;
        #1 check("mid wr addr0", write_addr, 32'h300);
        @(negedge clk);
        #1 check("mid wr addr1", write_addr, 32'h304);
        @(negedge clk);
        #1 check("mid wr addr2", write_addr, 32'h308);
        rst_n = 0;
        exp_beats = 0;
        #1;
        check("async reset write_valid", 32'(write_valid), 0);
        check("async reset addr", write_addr, 0);
        check_idle_outputs("async reset");
        wd_valid = 0; write_ready = 0;
        @(negedge clk);
        rst_n = 1;
        issue(0, 32'h10, 0, '1, '1);

        // cmd_valid held across back-to-back bursts
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; cmd_len = 0; read_ready = 1;
        @(negedge clk);
        cmd_write = 1; cmd_addr = 32'h80; wd_valid = 1; write_ready = 1; wd_data = 32'hC0DE;
        #1;
        check("b2b read_valid", 32'(read_valid), 1);
        check("b2b read_addr", read_addr, 32'h40);
        check("b2b no write overlap", 32'(write_valid), 0);
        @(negedge clk);
        #1;
        check("b2b done first", 32'(done), 1);
        check("b2b cmd_ready with done", 32'(cmd_ready), 1);
        check("b2b valids idle", 32'(write_valid | read_valid), 0);
        @(negedge clk);
        cmd_valid = 0;
        #1;
        check("b2b write_valid", 32'(write_valid), 1);
        check("b2b write_addr", write_addr, 32'h80);
        check("b2b no read overlap", 32'(read_valid), 0);
        @(negedge clk);
        exp_beats += 2;
        wd_valid = 0; write_ready = 0; read_ready = 0;
        #1;
        check("b2b done second", 32'(done), 1);
        check("b2b beats", beats_issued, exp_beats);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 32'h1FFF);
            issue(1'($urandom), a, 8'($urandom_range(0, 15)), $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_issuer.md
Name: axi_burst_issuer

Overview:
Upstream request stage for axi_memory. Accepts one burst command at a time: direction, word-aligned base address and beat count. Splits it into single-beat write or read requests on the memory's write_valid/write_ready and read_valid/read_ready ports, incrementing the address by 4 per beat. Write data comes from a separate valid/ready stream. Capturing read data is out of scope and belongs to the downstream consumer.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, write data width
LEN_W, 8, width of cmd_len (beats minus one; max burst 256 beats)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  burst command valid
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  base byte address; bits [1:0] ignored (forced 0)
cmd_len  in  LEN_W  beats minus one
wd_valid  in  1  write data beat valid
wd_ready  out  1  write data beat consumed
wd_data  in  DATA_W  write data beat
write_valid  out  1  single-beat write request to memory
write_ready  in  1  memory accepts write
write_addr  out  ADDR_W  write byte address
write_data  out  DATA_W  write data
read_valid  out  1  single-beat read request to memory
read_ready  in  1  memory accepts read
read_addr  out  ADDR_W  read byte address
busy  out  1  burst in progress
done  out  1  one-cycle pulse after the last beat handshake
err  out  1  one-cycle pulse when a command is rejected
beats_issued  out  32  total accepted beats; wraps modulo 2^32

Behaviour:
- Reset: state IDLE; cmd_ready=1; wd_ready=0; write_valid=0; read_valid=0; busy=0; done=0; err=0; beats_issued=0; write_addr=0; read_addr=0.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE: cmd_ready=1. Command handshake is cmd_valid&&cmd_ready.
  - On handshake: latch cur_addr={cmd_addr[ADDR_W-1:2],2'b00}, remaining=cmd_len, dir=cmd_write.
  - Next state is WR_BURST or RD_BURST, unless the burst is rejected (see err rule).
- Latency: command accepted in cycle N; first request valid in cycle N+1.
- WR_BURST:
  - write_valid=wd_valid (combinational); write_data=wd_data; write_addr=cur_addr; wd_ready=write_ready.
  - write_valid never depends on write_ready.
  - Beat completes on write_valid&&write_ready: cur_addr+=4, remaining-=1, beats_issued+=1.
  - wd_valid low stalls the burst with no beat lost.
- RD_BURST:
  - read_valid=1 (registered); read_addr=cur_addr; wd_ready=0.
  - Beat completes on read_valid&&read_ready.
- Last beat (remaining==0 at handshake): return to IDLE and assert done for exactly one cycle in the next cycle. cmd_ready returns to 1 in that same cycle.
- Throughput: one beat per cycle while ready and data are continuously high.
- While ready is low: address, data and valid hold stable until the handshake.
- write_valid and read_valid are never high in the same cycle. cmd_ready=0 whenever busy=1. busy=1 exactly in WR_BURST/RD_BURST.
- Boundary (err rule):
  - Reject if cur_addr[11:0] + (cmd_len+1)*4 > 4096, computed at 14 bits with no truncation.
  - On reject: command consumed, no beats issued, stay IDLE, err pulses one cycle in N+1, done not asserted.
  - A burst ending exactly at the 4 KB boundary is legal.
- cmd_len=0 issues a single beat.
- Address increment wraps modulo 2^ADDR_W; the 4 KB rule makes this unreachable for legal bursts.
- Reset mid-burst: all in-flight state discarded immediately (asynchronous). No partial-burst resume; outputs return to reset values.

Decomposition:
- Shared package burst_pkg holds:
  - typedef enum burst_state_t {IDLE, WR_BURST, RD_BURST}
  - localparam BEAT_BYTES=4
  - localparam BOUNDARY_BYTES=4096
- Single module; no sub-module needed.
- The memory-side ports connect one-to-one to axi_memory's write/read request signals.

Test Plan:
- Write burst, cmd_addr=0x100, len=3, wd 0xA0..0xA3, ready always 1 -> write_addr 0x100,0x104,0x108,0x10C in four consecutive cycles with matching data; done one cycle after the last beat; beats_issued=4.
- Read burst, addr=0x203 (unaligned), len=1, read_ready low for 2 cycles on beat 0 -> read_addr holds 0x200 while stalled, then 0x204; done pulses once.
- Write burst, len=2, wd_valid gapped (1,0,0,1,1) -> write_valid follows wd_valid; exactly 3 beats issued, no duplicated or lost data.
- Boundary: addr=0xFF8, len=1 -> accepted (ends at 0x1000); addr=0xFFC, len=1 -> err pulse, no valid asserted, beats_issued unchanged.
- Reset asserted mid write burst after 2 of 5 beats -> write_valid=0, busy=0 immediately; after release a new read burst len=0 at 0x10 issues a single read at 0x10.
- cmd_valid held high across back-to-back bursts -> second command accepted the cycle done pulses; read and write valids never overlap.
